counter_link: RTL and testbench

- Host-side link engine for the dual-latch counter block.
- Watches the counter's two ready flags and serialises each latched value as a framed byte stream toward the USB/UART byte FIFO.
- Decodes host command bytes into latch-request and latch-reset controls for the counter.
- Implements the slave side of the 00/01/02/03 byte protocol.

---
 rtl/counter_link_if.sv | 28 ++
 rtl/counter_link.sv | 194 +++++++++++++++++++
 tb/tb_counter_link.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_link_if.sv
// Byte-stream link between the counter link engine and the host byte FIFO.
//   oTxData/oTxValid : outgoing framed bytes (engine -> FIFO)
//   iTxReady         : FIFO accepts the byte this cycle
//   iRxData/iRxValid : host command byte strobe (no backpressure)
// The engine uses the slave modport; the host/FIFO side uses master.
interface counter_link_if;
  logic [7:0] oTxData;
  logic       oTxValid;
  logic       iTxReady;
  logic [7:0] iRxData;
  logic       iRxValid;

  modport slave (
    output oTxData,
    output oTxValid,
    input  iTxReady,
    input  iRxData,
    input  iRxValid
  );

  modport master (
    input  oTxData,
    input  oTxValid,
    output iTxReady,
    output iRxData,
    output iRxValid
  );
endinterface

// File: rtl/counter_link.sv
// Host-side link engine for the dual-latch counter block.
// Serialises each newly latched counter value as a frame {tag, NB bytes LSB
// first} onto the byte link, and decodes host command bytes into latch
// request / latch release controls.
//   iCLK, iRST     : clock, synchronous active-high reset
//   iRdyN/iLoN/iHiN: channel N latched-value flag and value
//   oLatchN        : level latch request to channel N
//   oResetLatchN   : one-cycle latch release pulse to channel N
//   oBusy          : transmit engine not idle
//   oRxErr         : one-cycle pulse on a rejected command byte
//   link           : byte stream (slave side)
module counter_link #(
  parameter int unsigned pWIDTH = 40
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iRdy1,
  input  logic [31:0] iLo1,
  input  logic [31:0] iHi1,
  input  logic        iRdy2,
  input  logic [31:0] iLo2,
  input  logic [31:0] iHi2,
  output logic        oLatch1,
  output logic        oLatch2,
  output logic        oResetLatch1,
  output logic        oResetLatch2,
  output logic        oBusy,
  output logic        oRxErr,
  counter_link_if.slave link
);

  localparam int unsigned NB = pWIDTH / 8;
  localparam int unsigned IW = $clog2(NB);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAG  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [pWIDTH-1:0]   shift_q, shift_d;
  logic                chan_q, chan_d;
  logic                sent1_q, sent1_d;
  logic                sent2_q, sent2_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                busy_q, busy_d;
  logic                latch1_q, latch1_d;
  logic                latch2_q, latch2_d;
  logic                rst_latch1_q, rst_latch1_d;
  logic                rst_latch2_q, rst_latch2_d;
  logic                rx_err_q, rx_err_d;

  logic                xfer;
  logic                frame_done;

  // Next-state for the transmit engine, sent flags and command decoder.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    chan_d       = chan_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    latch1_d     = latch1_q;
    latch2_d     = latch2_q;
    rst_latch1_d = 1'b0;
    rst_latch2_d = 1'b0;
    rx_err_d     = 1'b0;
    frame_done   = 1'b0;
    xfer         = tx_valid_q & link.iTxReady;

    case (state_q)
      ST_IDLE: begin
        // Channel 1 has fixed priority; the value is snapshotted here so
        // later input changes cannot disturb the frame.
        if (iRdy1 && !sent1_q) begin
          chan_d     = 1'b0;
          shift_d    = pWIDTH'({iHi1, iLo1});
          tx_data_d  = 8'h00;
          tx_valid_d = 1'b1;
          state_d    = ST_TAG;
        end else if (iRdy2 && !sent2_q) begin
          chan_d     = 1'b1;
          shift_d    = pWIDTH'({iHi2, iLo2});
          tx_data_d  = 8'h01;
          tx_valid_d = 1'b1;
          state_d    = ST_TAG;
        end
      end
      ST_TAG: begin
        if (xfer) begin
          idx_d     = '0;
          tx_data_d = shift_q[7:0];
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          if (idx_q == IW'(NB - 1)) begin
            tx_valid_d = 1'b0;
            frame_done = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            // Low byte is on the wire; next byte is the one above it.
            idx_d     = idx_q + IW'(1);
            shift_d   = shift_q >> 8;
            tx_data_d = shift_q[15:8];
          end
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);

    // A dropped ready flag re-arms the channel for its next latch event.
    sent1_d = sent1_q | (frame_done & ~chan_q);
    sent2_d = sent2_q | (frame_done & chan_q);
    if (!iRdy1) sent1_d = 1'b0;
    if (!iRdy2) sent2_d = 1'b0;

    // Latch request drops the cycle after its release pulse.
    if (rst_latch1_q) latch1_d = 1'b0;
    if (rst_latch2_q) latch2_d = 1'b0;

    if (link.iRxValid) begin
      case (link.iRxData)
        8'h00: begin
          // Ack counts only if the channel is still latched and was sent.
          if (sent1_q && iRdy1) rst_latch1_d = 1'b1;
          else                  rx_err_d     = 1'b1;
        end
        8'h01: begin
          if (sent2_q && iRdy2) rst_latch2_d = 1'b1;
          else                  rx_err_d     = 1'b1;
        end
        8'h02:   latch1_d = 1'b1;
        8'h03:   latch2_d = 1'b1;
        default: rx_err_d = 1'b1;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      shift_q      <= '0;
      chan_q       <= 1'b0;
      sent1_q      <= 1'b0;
      sent2_q      <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      latch1_q     <= 1'b0;
      latch2_q     <= 1'b0;
      rst_latch1_q <= 1'b0;
      rst_latch2_q <= 1'b0;
      rx_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      chan_q       <= chan_d;
      sent1_q      <= sent1_d;
      sent2_q      <= sent2_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      latch1_q     <= latch1_d;
      latch2_q     <= latch2_d;
      rst_latch1_q <= rst_latch1_d;
      rst_latch2_q <= rst_latch2_d;
      rx_err_q     <= rx_err_d;
    end
  end

  assign link.oTxData  = tx_data_q;
  assign link.oTxValid = tx_valid_q;
  assign oBusy         = busy_q;
  assign oLatch1       = latch1_q;
  assign oLatch2       = latch2_q;
  assign oResetLatch1  = rst_latch1_q;
  assign oResetLatch2  = rst_latch2_q;
  assign oRxErr        = rx_err_q;

endmodule

// File: tb/tb_counter_link.sv
// Self-checking bench for counter_link: frames are predicted from the
// channel value (tag byte then value bytes LSB first) and compared with
// what the byte sink actually accepts.
module tb_counter_link;

  localparam int unsigned W  = 40;
  localparam int unsigned NB = W / 8;
  localparam int unsigned FL = NB + 1;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iRdy1, iRdy2;
  logic [31:0] iLo1, iHi1, iLo2, iHi2;
  logic        oLatch1, oLatch2, oResetLatch1, oResetLatch2, oBusy, oRxErr;

  counter_link_if link ();

  counter_link #(.pWIDTH(W)) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iRdy1        (iRdy1),
    .iLo1         (iLo1),
    .iHi1         (iHi1),
    .iRdy2        (iRdy2),
    .iLo2         (iLo2),
    .iHi2         (iHi2),
    .oLatch1      (oLatch1),
    .oLatch2      (oLatch2),
    .oResetLatch1 (oResetLatch1),
    .oResetLatch2 (oResetLatch2),
    .oBusy        (oBusy),
    .oRxErr       (oRxErr),
    .link         (link)
  );

  always #5 iCLK = ~iCLK;

  int total = 0;
  int bad   = 0;

  logic [7:0] got_q[$];
  int         stall_bad;
  int         gap_bad;
  bit         tmo;

  // Expected byte i of a frame for channel ch carrying value v.
  function automatic logic [7:0] frame_byte(input bit ch, input logic [63:0] v, input int i);
    if (i == 0) return {7'd0, ch};
    return v[8*(i-1) +: 8];
  endfunction

  // Acts as the byte sink: accepts n bytes with the chosen ready pattern
  // (0 always, 1 toggling, 2 random), noting stall instability and missing
  // idle gaps after each complete frame. Returns on the negedge after the
  // last accepted byte.
  task automatic capture(input int n, input int mode, input bit scramble);
    bit         stalled = 0;
    bit         gap_pend = 0;
    bit         rdy_t = 1;
    bit         r;
    logic [7:0] held = '0;
    int         cyc = 0;
    got_q.delete();
    stall_bad = 0;
    gap_bad   = 0;
    tmo       = 0;
    while (got_q.size() < n) begin
      if (cyc > 400) begin
        tmo = 1;
        break;
      end
      if (cyc > 0 && scramble) begin
        iLo1 = $urandom;
        iHi1 = $urandom;
      end
      if (stalled && (link.oTxValid !== 1'b1 || link.oTxData !== held)) stall_bad++;
      if (gap_pend && link.oTxValid !== 1'b0) gap_bad++;
      gap_pend = 0;
      case (mode)
        0:       r = 1'b1;
        1:       begin r = rdy_t; rdy_t = ~rdy_t; end
        default: r = 1'($urandom_range(0, 1));
      endcase
      link.iTxReady = r;
      stalled = 0;
      if (link.oTxValid === 1'b1) begin
        if (r) begin
          got_q.push_back(link.oTxData);
          if (got_q.size() % FL == 0) gap_pend = 1;
        end else begin
          stalled = 1;
          held    = link.oTxData;
        end
      end
      @(negedge iCLK);
      cyc++;
    end
    link.iTxReady = 1'b0;
    if (gap_pend && link.oTxValid !== 1'b0) gap_bad++;
  endtask

  // One-cycle host command strobe; returns when its result is visible.
  task automatic rx_strobe(input logic [7:0] b);
    link.iRxData  = b;
    link.iRxValid = 1'b1;
    @(negedge iCLK);
    link.iRxValid = 1'b0;
  endtask

  task automatic test_reset;
    iRST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      iRdy1 = 1'($urandom); iRdy2 = 1'($urandom);
      iLo1 = $urandom; iHi1 = $urandom; iLo2 = $urandom; iHi2 = $urandom;
      link.iTxReady = 1'($urandom); link.iRxValid = 1'($urandom);
      link.iRxData = 8'($urandom);
      @(negedge iCLK);
      total++;
      if ({oLatch1, oLatch2, oResetLatch1, oResetLatch2, oBusy, oRxErr,
           link.oTxValid, link.oTxData} !== 15'd0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got=%h want=0", c,
                 {oLatch1, oLatch2, oResetLatch1, oResetLatch2, oBusy, oRxErr,
                  link.oTxValid, link.oTxData});
      end
    end
    iRST = 1'b0;
    iRdy1 = 0; iRdy2 = 0; link.iTxReady = 0; link.iRxValid = 0;
    @(negedge iCLK);
    total++;
    if (link.oTxValid !== 1'b0 || oBusy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset valid=%b busy=%b want 0 0", link.oTxValid, oBusy);
    end
  endtask

  task automatic test_single;
    logic [63:0] v;
    iLo1 = 32'h3456789A; iHi1 = 32'h12;
    v = {iHi1, iLo1};
    iRdy1 = 1'b1;
    capture(FL, 0, 0);
    total++;
    if (tmo || stall_bad != 0 || gap_bad != 0) begin
      bad++;
      $display("FAIL single_flow tmo=%0d stall=%0d gap=%0d want 0 0 0", tmo, stall_bad, gap_bad);
    end
    for (int i = 0; i < FL; i++) begin
      total++;
      if (got_q[i] !== frame_byte(0, v, i)) begin
        bad++;
        $display("FAIL single_byte[%0d] got=%h want=%h", i, got_q[i], frame_byte(0, v, i));
      end
    end
    link.iTxReady = 1'b1;
    for (int c = 0; c < 8; c++) begin
      total++;
      if (link.oTxValid !== 1'b0 || oBusy !== 1'b0) begin
        bad++;
        $display("FAIL no_resend cyc=%0d valid=%b busy=%b want 0 0", c, link.oTxValid, oBusy);
      end
      @(negedge iCLK);
    end
    link.iTxReady = 1'b0;
  endtask

  task automatic test_ack_relatch;
    logic [63:0] v;
    rx_strobe(8'h00);
    total++;
    if (oResetLatch1 !== 1'b1 || oRxErr !== 1'b0) begin
      bad++;
      $display("FAIL ack1_pulse rl1=%b err=%b want 1 0", oResetLatch1, oRxErr);
    end
    @(negedge iCLK);
    total++;
    if (oResetLatch1 !== 1'b0) begin
      bad++;
      $display("FAIL ack1_width rl1=%b want 0", oResetLatch1);
    end
    iRdy1 = 1'b0;
    @(negedge iCLK);
    iLo1 = 32'h1; iHi1 = 32'h0;
    v = {iHi1, iLo1};
    iRdy1 = 1'b1;
    capture(FL, 0, 0);
    for (int i = 0; i < FL; i++) begin
      total++;
      if (got_q[i] !== frame_byte(0, v, i)) begin
        bad++;
        $display("FAIL relatch_byte[%0d] got=%h want=%h", i, got_q[i], frame_byte(0, v, i));
      end
    end
  endtask

  task automatic test_priority_stall;
    logic [63:0] v1, v2;
    iRdy1 = 0; iRdy2 = 0;
    @(negedge iCLK);
    iLo1 = $urandom; iHi1 = $urandom; iLo2 = $urandom; iHi2 = $urandom;
    v1 = {iHi1, iLo1}; v2 = {iHi2, iLo2};
    iRdy1 = 1; iRdy2 = 1;
    capture(2 * FL, 1, 1);
    total++;
    if (tmo || stall_bad != 0 || gap_bad != 0) begin
      bad++;
      $display("FAIL prio_flow tmo=%0d stall=%0d gap=%0d want 0 0 0", tmo, stall_bad, gap_bad);
    end
    for (int i = 0; i < 2 * FL; i++) begin
      logic [7:0] e;
      e = (i < FL) ? frame_byte(0, v1, i) : frame_byte(1, v2, i - FL);
      total++;
      if (got_q[i] !== e) begin
        bad++;
        $display("FAIL prio_byte[%0d] got=%h want=%h", i, got_q[i], e);
      end
    end
  endtask

  task automatic test_random_frames;
    for (int it = 0; it < 6; it++) begin
      logic [63:0] v1, v2;
      logic [7:0]  exp_q[$];
      int          mask;
      iRdy1 = 0; iRdy2 = 0;
      @(negedge iCLK);
      mask = $urandom_range(1, 3);
      iLo1 = $urandom; iHi1 = $urandom; iLo2 = $urandom; iHi2 = $urandom;
      v1 = {iHi1, iLo1}; v2 = {iHi2, iLo2};
      exp_q.delete();
      if (mask[0]) for (int i = 0; i < FL; i++) exp_q.push_back(frame_byte(0, v1, i));
      if (mask[1]) for (int i = 0; i < FL; i++) exp_q.push_back(frame_byte(1, v2, i));
      iRdy1 = mask[0]; iRdy2 = mask[1];
      capture(exp_q.size(), 2, 1);
      total++;
      if (tmo || stall_bad != 0 || gap_bad != 0) begin
        bad++;
        $display("FAIL rand_flow it=%0d tmo=%0d stall=%0d gap=%0d want 0 0 0", it, tmo, stall_bad, gap_bad);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL rand_byte it=%0d [%0d] got=%h want=%h", it, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_latch_cmds;
    iRdy1 = 0; iRdy2 = 0;
    @(negedge iCLK);
    iLo1 = $urandom; iHi1 = $urandom;
    iRdy1 = 1;
    capture(FL, 0, 0);
    rx_strobe(8'h02);
    total++;
    if (oLatch1 !== 1'b1 || oRxErr !== 1'b0) begin
      bad++;
      $display("FAIL latch1_set l1=%b err=%b want 1 0", oLatch1, oRxErr);
    end
    rx_strobe(8'h02);
    total++;
    if (oLatch1 !== 1'b1 || oRxErr !== 1'b0) begin
      bad++;
      $display("FAIL latch1_again l1=%b err=%b want 1 0", oLatch1, oRxErr);
    end
    rx_strobe(8'h00);
    total++;
    if (oResetLatch1 !== 1'b1 || oLatch1 !== 1'b1) begin
      bad++;
      $display("FAIL release1 rl1=%b l1=%b want 1 1", oResetLatch1, oLatch1);
    end
    @(negedge iCLK);
    total++;
    if (oLatch1 !== 1'b0 || oResetLatch1 !== 1'b0) begin
      bad++;
      $display("FAIL latch1_drop l1=%b rl1=%b want 0 0", oLatch1, oResetLatch1);
    end
    rx_strobe(8'h03);
    total++;
    if (oLatch2 !== 1'b1 || oLatch1 !== 1'b0) begin
      bad++;
      $display("FAIL latch2_set l2=%b l1=%b want 1 0", oLatch2, oLatch1);
    end
  endtask

  task automatic test_errors;
    rx_strobe(8'h07);
    total++;
    if (oRxErr !== 1'b1 || oResetLatch1 !== 1'b0 || oResetLatch2 !== 1'b0 || oLatch2 !== 1'b1) begin
      bad++;
      $display("FAIL bad_cmd err=%b rl1=%b rl2=%b l2=%b want 1 0 0 1",
               oRxErr, oResetLatch1, oResetLatch2, oLatch2);
    end
    @(negedge iCLK);
    total++;
    if (oRxErr !== 1'b0) begin
      bad++;
      $display("FAIL err_width err=%b want 0", oRxErr);
    end
    iRdy2 = 1'b0;
    @(negedge iCLK);
    rx_strobe(8'h01);
    total++;
    if (oRxErr !== 1'b1 || oResetLatch2 !== 1'b0) begin
      bad++;
      $display("FAIL ack2_unsent err=%b rl2=%b want 1 0", oRxErr, oResetLatch2);
    end
    // Channel 1 was sent and is still latched; ack lands as iRdy1 drops.
    iRdy1 = 1'b0;
    rx_strobe(8'h00);
    total++;
    if (oRxErr !== 1'b1 || oResetLatch1 !== 1'b0) begin
      bad++;
      $display("FAIL ack1_clearing err=%b rl1=%b want 1 0", oRxErr, oResetLatch1);
    end
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      b = 8'($urandom_range(4, 255));
      rx_strobe(b);
      total++;
      if (oRxErr !== 1'b1) begin
        bad++;
        $display("FAIL rand_bad_cmd %h err=%b want 1", b, oRxErr);
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [63:0] v;
    iRdy1 = 0; iRdy2 = 0;
    @(negedge iCLK);
    iLo1 = $urandom; iHi1 = $urandom;
    v = {iHi1, iLo1};
    iRdy1 = 1;
    capture(3, 0, 0);
    total++;
    if (link.oTxValid !== 1'b1) begin
      bad++;
      $display("FAIL midframe_active valid=%b want 1", link.oTxValid);
    end
    iRST = 1'b1;
    @(negedge iCLK);
    total++;
    if (link.oTxValid !== 1'b0 || oBusy !== 1'b0 || oLatch2 !== 1'b0) begin
      bad++;
      $display("FAIL midframe_abort valid=%b busy=%b l2=%b want 0 0 0", link.oTxValid, oBusy, oLatch2);
    end
    iRST = 1'b0;
    capture(FL, 0, 0);
    for (int i = 0; i < FL; i++) begin
      total++;
      if (got_q[i] !== frame_byte(0, v, i)) begin
        bad++;
        $display("FAIL restart_byte[%0d] got=%h want=%h", i, got_q[i], frame_byte(0, v, i));
      end
    end
  endtask

  initial begin
    iRST = 1'b1;
    iRdy1 = 0; iRdy2 = 0; iLo1 = 0; iHi1 = 0; iLo2 = 0; iHi2 = 0;
    link.iTxReady = 0; link.iRxValid = 0; link.iRxData = 0;
    @(negedge iCLK);
    test_reset();
    test_single();
    test_ack_relatch();
    test_priority_stall();
    test_random_frames();
    test_latch_cmds();
    test_errors();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
